// File: rtl/sipo_right_rx.sv
// LSB-first serial-in parallel-out receiver with a one-word valid/ready output buffer.
// Optional trailing even-parity bit when SIPO_PARITY_EN is defined.
module sipo_right_rx #(
    parameter int OUTPUT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    serial_in,
    input  logic                    shift_en,
    input  logic                    sync,
    output logic [OUTPUT_WIDTH-1:0] data_out,
    output logic                    data_valid,
    input  logic                    data_ready,
    output logic                    busy,
    output logic                    overflow,
`ifdef SIPO_PARITY_EN
    output logic                    parity_err,
`endif
    input  logic                    clr_ovf
);

    localparam int W = OUTPUT_WIDTH;
`ifdef SIPO_PARITY_EN
    localparam int FRAME_LEN = W + 1;
`else
    localparam int FRAME_LEN = W;
`endif
    localparam int CW = $clog2(W + 2);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

`ifdef SIPO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t          state, state_n;
    logic [W-1:0]    shreg, shreg_n;
    logic [CW-1:0]   bit_cnt, cnt_n;
    logic [W-1:0]    dout_n, word;
    logic            valid_n, ovf_n, done, busy_n;
    logic            perr, perr_n, perr_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            perr       <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bit_cnt    <= cnt_n;
            data_out   <= dout_n;
            data_valid <= valid_n;
            overflow   <= ovf_n;
            busy       <= busy_n;
            perr       <= perr_n;
        end
    end

    always_comb begin
        shreg_n   = shreg;
        cnt_n     = bit_cnt;
        dout_n    = data_out;
        valid_n   = data_valid;
        ovf_n     = overflow;
        perr_n    = perr;
        done      = 1'b0;
        word      = shreg;
        perr_word = 1'b0;

        if (clr_ovf)
            ovf_n = 1'b0;
        if (data_valid && data_ready)
            valid_n = 1'b0;

        if (sync) begin
            // A sampled bit on the restart edge opens the new frame.
            shreg_n = '0;
            cnt_n   = '0;
            if (shift_en) begin
                shreg_n = {serial_in, {(W-1){1'b0}}};
                cnt_n   = CW'(1);
            end
        end else if (shift_en) begin
            unique case (state)
                IDLE, SHIFT: begin
                    shreg_n = {serial_in, shreg[W-1:1]};
                    if (bit_cnt == LAST) begin
                        done  = 1'b1;
                        cnt_n = '0;
                        word  = shreg_n;
                    end else begin
                        cnt_n = bit_cnt + 1'b1;
                    end
                end
`ifdef SIPO_PARITY_EN
                PAR: begin
                    done      = 1'b1;
                    cnt_n     = '0;
                    word      = shreg;
                    perr_word = ^{serial_in, shreg};
                end
`endif
                default: ;
            endcase
        end

        if (done) begin
            if (!data_valid || data_ready) begin
                dout_n  = word;
                valid_n = 1'b1;
                perr_n  = perr_word;
            end else begin
                ovf_n = 1'b1;
            end
        end

        busy_n = (cnt_n != '0);

        if (cnt_n == '0)
            state_n = IDLE;
`ifdef SIPO_PARITY_EN
        else if (cnt_n == CW'(W))
            state_n = PAR;
`endif
        else
            state_n = SHIFT;
    end

`ifdef SIPO_PARITY_EN
    assign parity_err = perr;
`endif

endmodule

// File: tb/tb_sipo_right_rx.sv
// Directed self-checking bench for sipo_right_rx (OUTPUT_WIDTH=8).
// Parity checks are included when SIPO_PARITY_EN is defined.
module tb_sipo_right_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       serial_in;
    logic       shift_en;
    logic       sync;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       busy;
    logic       overflow;
    logic       clr_ovf;
`ifdef SIPO_PARITY_EN
    logic       parity_err;
`endif

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sipo_right_rx #(.OUTPUT_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .serial_in  (serial_in),
        .shift_en   (shift_en),
        .sync       (sync),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .overflow   (overflow),
`ifdef SIPO_PARITY_EN
        .parity_err (parity_err),
`endif
        .clr_ovf    (clr_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] w, input int first,
                             input int n);
        for (int i = first; i < first + n; i++) begin
            serial_in = w[i];
            shift_en  = 1'b1;
            tick();
            shift_en  = 1'b0;
        end
    endtask

    task automatic send_one(input logic b);
        serial_in = b;
        shift_en  = 1'b1;
        tick();
        shift_en  = 1'b0;
    endtask

    // Everything in the frame except its final (completing) bit.
    task automatic send_head(input logic [7:0] w, input int first);
`ifdef SIPO_PARITY_EN
        send_bits(w, first, 8 - first);
`else
        send_bits(w, first, 7 - first);
`endif
    endtask

    task automatic send_tail(input logic [7:0] w);
`ifdef SIPO_PARITY_EN
        send_one(^w);
`else
        send_one(w[7]);
`endif
    endtask

    task automatic send_frame(input logic [7:0] w);
        send_head(w, 0);
        send_tail(w);
    endtask

    initial begin
        rst_n      = 1'b0;
        serial_in  = 1'b0;
        shift_en   = 1'b0;
        sync       = 1'b0;
        data_ready = 1'b0;
        clr_ovf    = 1'b0;
        @(negedge clk);
        chk("rst_data", data_out, 8'h00);
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        rst_n = 1'b1;
        tick();

        // 1: A5 arrives LSB first
        send_bits(8'hA5, 0, 1);
        chk("t1_busy_mid", busy, 1'b1);
        send_head(8'hA5, 1);
        send_tail(8'hA5);
        chk("t1_data", data_out, 8'hA5);
        chk("t1_valid", data_valid, 1'b1);
        chk("t1_busy", busy, 1'b0);

        // 2: overflow while A5 unconsumed, then clear
        send_frame(8'h3C);
        chk("t2_ovf", overflow, 1'b1);
        chk("t2_keep", data_out, 8'hA5);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t2_clr", overflow, 1'b0);
        send_head(8'h11, 0);
        clr_ovf = 1'b1;
        send_tail(8'h11);
        clr_ovf = 1'b0;
        chk("t2_set_wins", overflow, 1'b1);
        chk("t2_keep2", data_out, 8'hA5);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;

        // 3: transfer and completion on the same edge
        send_head(8'h5A, 0);
        chk("t3_valid_pre", data_valid, 1'b1);
        data_ready = 1'b1;
        send_tail(8'h5A);
        chk("t3_data", data_out, 8'h5A);
        chk("t3_valid", data_valid, 1'b1);
        chk("t3_ovf", overflow, 1'b0);
        tick();
        data_ready = 1'b0;
        chk("t3_drain", data_valid, 1'b0);

        // 4: sync discards a partial word
        send_bits(8'hFF, 0, 3);
        chk("t4_busy", busy, 1'b1);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        chk("t4_sync_idle", busy, 1'b0);
        send_frame(8'h0F);
        chk("t4_data", data_out, 8'h0F);
        chk("t4_valid", data_valid, 1'b1);
        chk("t4_ovf", overflow, 1'b0);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        tick();
        chk("t4_one_word", data_valid, 1'b0);

        // sync with shift_en: the sampled bit is bit 0 of the new frame
        send_bits(8'h00, 0, 2);
        serial_in = 1'b1;
        shift_en  = 1'b1;
        sync      = 1'b1;
        tick();
        sync      = 1'b0;
        shift_en  = 1'b0;
        chk("t4_sync_shift_busy", busy, 1'b1);
        send_head(8'h81, 1);
        send_tail(8'h81);
        chk("t4_sync_shift", data_out, 8'h81);

        // 5: async reset mid-frame with a valid word and overflow pending
        send_frame(8'hC3);
        chk("t5_ovf_pre", overflow, 1'b1);
        send_bits(8'hC3, 0, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_data", data_out, 8'h00);
        chk("t5_rst_valid", data_valid, 1'b0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_ovf", overflow, 1'b0);
`ifdef SIPO_PARITY_EN
        chk("t5_rst_perr", parity_err, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send_frame(8'hC3);
        chk("t5_data", data_out, 8'hC3);
        chk("t5_valid", data_valid, 1'b1);

`ifdef SIPO_PARITY_EN
        // 6: even parity good / bad
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        send_bits(8'hA5, 0, 8);
        send_one(1'b0);
        chk("t6_perr0", parity_err, 1'b0);
        chk("t6_data0", data_out, 8'hA5);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        send_bits(8'hA5, 0, 8);
        send_one(1'b1);
        chk("t6_perr1", parity_err, 1'b1);
        chk("t6_data1", data_out, 8'hA5);
        chk("t6_valid1", data_valid, 1'b1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
